// File: rtl/apb_deconcatenator.sv
// APB requester: pops request words from a show-ahead FIFO, runs one APB
// transfer per word, and pushes a {rdata, slverr, write_read} response word.
module apb_deconcatenator #(
    parameter int DATASIZE           = 32,
    parameter int ADDRSIZE           = 32,
    parameter int TOP_FIFO_DATA_SIZE = DATASIZE + ADDRSIZE + 4 + DATASIZE / 8,
    parameter int TIMEOUT            = 16
) (
    input  logic                          APB_clk,
    input  logic                          APB_rst,
    input  logic [TOP_FIFO_DATA_SIZE-1:0] rdata_top,
    input  logic                          rempty_top,
    output logic                          rinc_top,
    input  logic                          wfull_bottom,
    output logic                          winc_bottom,
    output logic [DATASIZE+1:0]           wdata_bottom,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [ADDRSIZE-1:0]           PADDR,
    output logic [2:0]                    PPROT,
    output logic [DATASIZE-1:0]           PWDATA,
    output logic [DATASIZE/8-1:0]         PSTRB,
    input  logic                          PREADY,
    input  logic                          PSLVERR,
    input  logic [DATASIZE-1:0]           PRDATA
);

    localparam int SW = DATASIZE / 8;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t                          state;
    state_t                          state_next;
    logic [TOP_FIFO_DATA_SIZE-1:0]   req_q;
    logic [CW-1:0]                   wait_q;

    logic                            req_wr;
    logic [SW-1:0]                   req_strb;

    assign req_wr   = req_q[0];
    assign req_strb = req_q[ADDRSIZE+4 +: SW];

    // Address/control come straight from the request register, so they hold
    // steady through SETUP and ACCESS and read as zero while in reset.
    assign PWRITE = req_wr;
    assign PADDR  = req_q[ADDRSIZE:1];
    assign PPROT  = req_q[ADDRSIZE+3:ADDRSIZE+1];
    assign PWDATA = req_q[ADDRSIZE+4+SW +: DATASIZE];
    assign PSTRB  = req_wr ? req_strb : {SW{1'b0}};

    always_ff @(posedge APB_clk or posedge APB_rst) begin
        if (APB_rst) begin
            state  <= IDLE;
            req_q  <= '0;
            wait_q <= '0;
        end else begin
            state <= state_next;
            if (rinc_top) begin
                req_q <= rdata_top;
            end
            if (state == SETUP) begin
                wait_q <= '0;
            end else if (state == ACCESS && !PREADY) begin
                wait_q <= wait_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        rinc_top     = 1'b0;
        winc_bottom  = 1'b0;
        wdata_bottom = '0;
        PSEL         = 1'b0;
        PENABLE      = 1'b0;
        unique case (state)
            IDLE: begin
                // Response slot is reserved here; the push later ignores full.
                if (!APB_rst && !rempty_top && !wfull_bottom) begin
                    rinc_top   = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                PSEL       = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    winc_bottom  = 1'b1;
                    wdata_bottom = {req_wr ? {DATASIZE{1'b0}} : PRDATA,
                                    PSLVERR, req_wr};
                    state_next   = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    winc_bottom  = 1'b1;
                    wdata_bottom = {{DATASIZE{1'b0}}, 1'b1, req_wr};
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_deconcatenator.sv
// Directed bench for apb_deconcatenator: write, read with wait states,
// timeout, backpressure, reset mid-transfer and back-to-back transfers.
module tb_apb_deconcatenator;

    logic        clk;
    logic        rst;
    logic [71:0] rdata_top;
    logic        rempty_top;
    logic        rinc_top;
    logic        wfull_bottom;
    logic        winc_bottom;
    logic [33:0] wdata_bottom;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    apb_deconcatenator dut (
        .APB_clk      (clk),
        .APB_rst      (rst),
        .rdata_top    (rdata_top),
        .rempty_top   (rempty_top),
        .rinc_top     (rinc_top),
        .wfull_bottom (wfull_bottom),
        .winc_bottom  (winc_bottom),
        .wdata_bottom (wdata_bottom),
        .PSEL         (psel),
        .PENABLE      (penable),
        .PWRITE       (pwrite),
        .PADDR        (paddr),
        .PPROT        (pprot),
        .PWDATA       (pwdata),
        .PSTRB        (pstrb),
        .PREADY       (pready),
        .PSLVERR      (pslverr),
        .PRDATA       (prdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small request FIFO model feeding the DUT, plus response recorder.
    logic [71:0] mem [0:15];
    int          head = 0;
    int          tail = 0;
    int          npop = 0;
    int          nresp = 0;
    int          cyc = 0;
    logic [33:0] resp [0:31];
    int          resp_cyc [0:31];

    assign rempty_top = (head == tail);
    assign rdata_top  = mem[head % 16];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rinc_top) begin
            head <= head + 1;
            npop <= npop + 1;
        end
        if (winc_bottom) begin
            resp[nresp % 32]     <= wdata_bottom;
            resp_cyc[nresp % 32] <= cyc;
            nresp                <= nresp + 1;
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [71:0] mk(input logic wr, input logic [31:0] a,
                                       input logic [2:0] p, input logic [3:0] s,
                                       input logic [31:0] d);
        return {d, s, p, a, wr};
    endfunction

    task automatic push(input logic [71:0] w);
        mem[tail % 16] = w;
        tail = tail + 1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    int base_n;
    int base_p;

    initial begin
        rst          = 1'b1;
        wfull_bottom = 1'b0;
        pready       = 1'b0;
        pslverr      = 1'b0;
        prdata       = 32'hFFFF_FFFF;

        // Reset: queued request must not be popped, outputs all zero
        tick();
        push(mk(1'b1, 32'h0000_1004, 3'b010, 4'hF, 32'hDEAD_BEEF));
        #1;
        chk("rst_rinc", rinc_top, 0);
        chk("rst_psel", {psel, penable, pwrite}, 0);
        chk("rst_winc", {winc_bottom, wdata_bottom}, 0);
        chk("rst_paddr", {paddr, pprot, pstrb}, 0);
        chk("rst_pwdata", pwdata, 0);

        // Write
        tick();
        rst = 1'b0;
        #1 chk("wr_pop", rinc_top, 1);
        tick();
        #1;
        chk("wr_setup", {psel, penable, pwrite, rinc_top}, 4'b1010);
        chk("wr_paddr", paddr, 32'h0000_1004);
        chk("wr_pprot", pprot, 3'b010);
        chk("wr_pstrb", pstrb, 4'hF);
        chk("wr_pwdata", pwdata, 32'hDEAD_BEEF);
        pready = 1'b1;
        tick();
        #1;
        chk("wr_access", {psel, penable, pwrite}, 3'b111);
        chk("wr_stable", {paddr, pstrb}, {32'h0000_1004, 4'hF});
        chk("wr_winc", winc_bottom, 1);
        chk("wr_wdata", wdata_bottom, 34'h1);
        tick();
        pready = 1'b0;
        #1;
        chk("wr_idle", {psel, penable, winc_bottom}, 0);
        chk("wr_counts", {npop[7:0], nresp[7:0]}, 16'h0101);

        // Read with three wait states
        prdata = 32'h1234_5678;
        push(mk(1'b0, 32'h20, 3'b000, 4'hF, 32'hCAFE_F00D));
        #1 chk("rd_pop", rinc_top, 1);
        tick();
        #1;
        chk("rd_setup", {psel, penable, pwrite}, 3'b100);
        chk("rd_pstrb", pstrb, 0);
        chk("rd_pwdata", pwdata, 32'hCAFE_F00D);
        chk("rd_paddr", paddr, 32'h20);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) pready = 1'b1;
            #1;
            chk("rd_access", {psel, penable, rinc_top}, 3'b110);
            chk("rd_winc", winc_bottom, (i == 3));
        end
        chk("rd_wdata", wdata_bottom, {32'h1234_5678, 1'b0, 1'b0});
        tick();
        pready = 1'b0;
        #1 chk("rd_idle", {psel, penable, winc_bottom}, 0);

        // Timeout: PREADY held low
        push(mk(1'b0, 32'h40, 3'b001, 4'h3, 32'h0));
        #1 chk("to_pop", rinc_top, 1);
        tick();
        #1 chk("to_setup", {psel, penable}, 2'b10);
        for (int i = 0; i < 16; i++) begin
            tick();
            #1;
            chk("to_access", {psel, penable}, 2'b11);
            chk("to_winc", winc_bottom, (i == 15));
        end
        chk("to_wdata", wdata_bottom, 34'h2);
        tick();
        #1 chk("to_idle", {psel, penable, winc_bottom}, 0);
        chk("to_resp", resp[2], 34'h2);

        // Backpressure
        wfull_bottom = 1'b1;
        push(mk(1'b1, 32'h80, 3'b000, 4'h1, 32'h55));
        #1 chk("bp_hold", {rinc_top, psel}, 0);
        tick();
        #1;
        chk("bp_hold2", {rinc_top, psel}, 0);
        chk("bp_npop", npop, 3);
        tick();
        wfull_bottom = 1'b0;
        #1 chk("bp_pop", rinc_top, 1);
        tick();
        pready = 1'b1;
        #1 chk("bp_setup", {psel, penable, pstrb}, 6'b10_0001);
        tick();
        wfull_bottom = 1'b1;
        #1 chk("bp_push_full", {winc_bottom, wdata_bottom}, {1'b1, 34'h1});
        tick();
        wfull_bottom = 1'b0;
        pready = 1'b0;
        #1 chk("bp_idle", psel, 0);

        // Reset during ACCESS
        push(mk(1'b1, 32'hC0, 3'b111, 4'hF, 32'hAAAA_5555));
        #1 chk("ra_pop", rinc_top, 1);
        tick();
        tick();
        #1 chk("ra_access", {psel, penable, pwrite}, 3'b111);
        push(mk(1'b1, 32'h100, 3'b000, 4'hC, 32'h0BAD_F00D));
        base_n = nresp;
        #1 rst = 1'b1;
        #1;
        chk("ra_ctrl", {psel, penable, pwrite, rinc_top, winc_bottom}, 0);
        chk("ra_addr", {paddr, pprot, pstrb}, 0);
        chk("ra_data", {pwdata, wdata_bottom}, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("ra_no_push", nresp, base_n);
        chk("ra_pop2", rinc_top, 1);
        tick();
        pready = 1'b1;
        #1 chk("ra_setup2", {psel, penable, paddr}, {2'b10, 32'h100});
        tick();
        #1 chk("ra_done2", {winc_bottom, wdata_bottom}, {1'b1, 34'h1});
        tick();

        // Back-to-back with PSLVERR on the middle transfer
        base_n = nresp;
        base_p = npop;
        push(mk(1'b0, 32'h200, 3'b000, 4'hF, 32'h0));
        push(mk(1'b0, 32'h204, 3'b000, 4'hF, 32'h0));
        push(mk(1'b0, 32'h208, 3'b000, 4'hF, 32'h0));
        for (int k = 0; k < 3; k++) begin
            #1 chk("bb_pop", rinc_top, 1);
            tick();
            #1 chk("bb_paddr", paddr, 32'h200 + 32'(4 * k));
            tick();
            pslverr = (k == 1);
            #1 chk("bb_resp", {winc_bottom, wdata_bottom},
                   {1'b1, 32'h1234_5678, (k == 1), 1'b0});
            tick();
            pslverr = 1'b0;
        end
        #1;
        chk("bb_npop", npop - base_p, 3);
        chk("bb_nresp", nresp - base_n, 3);
        chk("bb_r0", resp[base_n % 32], {32'h1234_5678, 2'b00});
        chk("bb_r1", resp[(base_n + 1) % 32], {32'h1234_5678, 2'b10});
        chk("bb_r2", resp[(base_n + 2) % 32], {32'h1234_5678, 2'b00});
        chk("bb_gap1", resp_cyc[(base_n + 1) % 32] - resp_cyc[base_n % 32], 3);
        chk("bb_gap2", resp_cyc[(base_n + 2) % 32] - resp_cyc[(base_n + 1) % 32], 3);
        chk("bb_idle", {psel, rinc_top, winc_bottom}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
